// File: rtl/uart_word_bridge_if.sv
// uart_word_bridge_if: AXI4-Lite channel bundle between the word bridge and a UART-Lite.
interface uart_word_bridge_if;
    logic        awvalid, awready;
    logic [3:0]  awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: moves WORD_BYTES-byte words through an AXI4-Lite UART-Lite by status polling.
// Define UART_POLL_TIMEOUT_EN to abort a byte after POLL_LIMIT not-ready status reads.
module uart_word_bridge #(
    parameter int WORD_BYTES = 1,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    u_ready,
    input  logic                    t_valid,
    input  logic [8*WORD_BYTES-1:0] t_data,
    input  logic                    r_valid,
    output logic [8*WORD_BYTES-1:0] r_data,
    output logic                    tx_done,
    output logic                    rx_done,
    output logic                    err,
    uart_word_bridge_if.master      axi
);
    localparam int W = 8 * WORD_BYTES;
    typedef enum logic [2:0] {IDLE, POLL_TX, WRITE, WRESP, POLL_RX, READ, DONE} state_t;
    state_t state, nstate;
    logic [W-1:0] word, shadow, shadow_n;
    logic [1:0] idx;
    logic [4:0] sh;
    logic is_rx, err_q, ar_ok, aw_ok, w_ok, rd_st, poll_st, r_hs, last, st_ok, aw_acc, w_acc, tmo;

    assign sh       = {idx, 3'b000};
    assign rd_st    = state inside {POLL_TX, POLL_RX, READ};
    assign poll_st  = state inside {POLL_TX, POLL_RX};
    assign r_hs     = rd_st && ar_ok && axi.rvalid;
    assign last     = idx == 2'(WORD_BYTES - 1);
    assign st_ok    = state == POLL_TX ? !axi.rdata[3] : axi.rdata[0];
    assign aw_acc   = aw_ok || axi.awready;
    assign w_acc    = w_ok || axi.wready;
    assign shadow_n = (shadow & ~(W'(8'hff) << sh)) | (W'(axi.rdata[7:0]) << sh);

`ifdef UART_POLL_TIMEOUT_EN
    localparam int CW = $clog2(POLL_LIMIT + 1);
    logic [CW-1:0] polls;
    assign tmo = poll_st && r_hs && !st_ok && polls == CW'(POLL_LIMIT - 1);
    // Counter restarts whenever a byte leaves polling, so the limit applies per byte.
    always_ff @(posedge clk)
        polls <= rst || !poll_st ? '0 : polls + CW'(r_hs);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        nstate = state;
        case (state)
            IDLE:             nstate = !u_ready ? IDLE : t_valid ? POLL_TX : r_valid ? POLL_RX : IDLE;
            POLL_TX, POLL_RX: nstate = tmo ? DONE : !(r_hs && st_ok) ? state : state == POLL_TX ? WRITE : READ;
            WRITE:            nstate = aw_acc && w_acc ? WRESP : WRITE;
            WRESP:            nstate = !axi.bvalid ? WRESP : last ? DONE : POLL_TX;
            READ:             nstate = !r_hs ? READ : last ? DONE : POLL_RX;
            default:          nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            u_ready <= 1'b0;
            idx     <= '0;
            is_rx   <= 1'b0;
            err_q   <= 1'b0;
            ar_ok   <= 1'b0;
            aw_ok   <= 1'b0;
            w_ok    <= 1'b0;
            word    <= '0;
            shadow  <= '0;
            r_data  <= '0;
        end else begin
            state   <= nstate;
            u_ready <= nstate == IDLE;
            ar_ok   <= rd_st && !r_hs && (ar_ok || axi.arready);
            aw_ok   <= state == WRITE && nstate == WRITE && aw_acc;
            w_ok    <= state == WRITE && nstate == WRITE && w_acc;
            if (state == IDLE && nstate != IDLE) begin
                word  <= t_data;
                idx   <= '0;
                err_q <= 1'b0;
                is_rx <= nstate == POLL_RX;
            end
            if ((state == WRESP && axi.bvalid) || (state == READ && r_hs)) begin
                idx   <= idx + 2'd1;
                err_q <= err_q || (state == WRESP ? axi.bresp != 2'b00 : axi.rresp != 2'b00);
            end
            if (tmo)
                err_q <= 1'b1;
            // r_data only changes once the final byte lands, so aborted receives leave it intact.
            if (state == READ && r_hs) begin
                shadow <= shadow_n;
                if (last)
                    r_data <= shadow_n;
            end
        end
    end

    assign axi.awvalid = state == WRITE && !aw_ok;
    assign axi.wvalid  = state == WRITE && !w_ok;
    assign axi.awaddr  = state == WRITE ? 4'h4 : 4'h0;
    assign axi.wdata   = state == WRITE ? {24'h0, 8'(word >> sh)} : 32'h0;
    assign axi.wstrb   = 4'b0001;
    assign axi.bready  = state == WRESP;
    assign axi.arvalid = rd_st && !ar_ok;
    assign axi.rready  = rd_st && ar_ok;
    assign axi.araddr  = state == READ ? 4'h0 : 4'h8;
    assign tx_done     = state == DONE && !is_rx;
    assign rx_done     = state == DONE && is_rx;
    assign err         = state == DONE && err_q;
endmodule

// File: tb/tb_uart_word_bridge.sv
// tb_uart_word_bridge: randomized and directed checks of the word bridge against a UART-Lite slave model.
module tb_uart_word_bridge;
    localparam int WB = 4;
    localparam int PL = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic u_ready, t_valid = 1'b0, r_valid = 1'b0, tx_done, rx_done, err;
    logic [8*WB-1:0] t_data = '0, r_data;
    always #5 clk = ~clk;

    uart_word_bridge_if axi();
    uart_word_bridge #(.WORD_BYTES(WB), .POLL_LIMIT(PL)) dut (
        .clk(clk), .rst(rst), .u_ready(u_ready), .t_valid(t_valid), .t_data(t_data),
        .r_valid(r_valid), .r_data(r_data), .tx_done(tx_done), .rx_done(rx_done), .err(err), .axi(axi)
    );

    int errors = 0, checks = 0;
    logic [7:0] stat_q[$], rx_q[$], wr_log[$];
    logic [1:0] bresp_q[$], rresp_q[$];
    logic [7:0] stat_def = 8'h00;
    int wr_stat_at[$];
    int aw_dly = 0, w_dly = 0;
    int n_stat = 0, n_rxrd = 0, n_txd = 0, n_rxd = 0, bad = 0;
    logic [8*WB-1:0] model_rdata = '0;

    // UART-Lite slave: one read at a time, write address/data accepted after configurable delays.
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rs, aw_got, w_got, ar_wait;
        logic [3:0] aa, wa, ga, ws, gs;
        logic [31:0] wd, gd;
        int awc, wc;
        aw_got = 0; w_got = 0; ar_wait = 0; awc = 0; wc = 0; ga = 0; gs = 0; gd = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        forever begin
            @(posedge clk);
            rs = rst;
            ar_hs = axi.arvalid && axi.arready; r_hs = axi.rvalid && axi.rready;
            aw_hs = axi.awvalid && axi.awready; w_hs = axi.wvalid && axi.wready;
            b_hs = axi.bvalid && axi.bready;
            aa = axi.araddr; wa = axi.awaddr; wd = axi.wdata; ws = axi.wstrb;
            if (!rs && ((axi.arvalid && ar_wait) || (axi.awvalid && aw_got) || (axi.wvalid && w_got))) bad++;
            #1;
            if (rs) begin
                aw_got = 0; w_got = 0; ar_wait = 0; awc = 0; wc = 0;
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
            end else begin
                if (r_hs) begin axi.rvalid = 0; ar_wait = 0; end
                if (ar_hs) begin
                    ar_wait = 1; axi.rvalid = 1; axi.rresp = 0;
                    axi.rdata = $urandom;
                    if (aa == 4'h8) begin
                        axi.rdata[7:0] = stat_def;
                        if (stat_q.size() > 0) axi.rdata[7:0] = stat_q.pop_front();
                        n_stat++;
                    end else begin
                        if (rx_q.size() > 0) axi.rdata[7:0] = rx_q.pop_front();
                        if (rresp_q.size() > 0) axi.rresp = rresp_q.pop_front();
                        if (aa != 4'h0) bad++;
                        n_rxrd++;
                    end
                end
                axi.arready = axi.arvalid && !ar_wait;
                if (b_hs) begin axi.bvalid = 0; aw_got = 0; w_got = 0; awc = 0; wc = 0; end
                if (aw_hs) begin aw_got = 1; ga = wa; end
                if (w_hs) begin w_got = 1; gd = wd; gs = ws; end
                if (aw_got && w_got && !axi.bvalid) begin
                    axi.bvalid = 1; axi.bresp = 0;
                    if (bresp_q.size() > 0) axi.bresp = bresp_q.pop_front();
                    if (ga != 4'h4 || gs != 4'b0001 || gd[31:8] != 24'h0) bad++;
                    wr_log.push_back(gd[7:0]);
                    wr_stat_at.push_back(n_stat);
                end
                axi.awready = axi.awvalid && !aw_got && awc >= aw_dly;
                if (axi.awvalid && !aw_got) awc++;
                axi.wready = axi.wvalid && !w_got && wc >= w_dly;
                if (axi.wvalid && !w_got) wc++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (tx_done) n_txd++;
        if (rx_done) n_rxd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic issue(input bit tx, input bit rx, input logic [8*WB-1:0] w);
        @(negedge clk);
        for (int c = 0; c < 100 && !u_ready; c++) @(negedge clk);
        t_valid = tx; r_valid = rx; t_data = w;
        @(posedge clk); #1;
        t_valid = 0; r_valid = 0; t_data = $urandom;
    endtask

    task automatic wait_done(output bit got, output bit e, output bit wt);
        got = 0; e = 0; wt = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (tx_done || rx_done) begin got = 1; e = err; wt = tx_done; end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if (u_ready !== 1'b0) begin errors++; $display("FAIL reset_u_ready: got %b want 0", u_ready); end
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, tx_done, rx_done, err} !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl: aw=%b w=%b b=%b ar=%b r=%b txd=%b rxd=%b err=%b want all 0",
                     axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, tx_done, rx_done, err);
        end
        checks++;
        if (axi.araddr !== 4'h8 || axi.wstrb !== 4'b0001 || axi.awaddr !== 4'h0 || axi.wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: araddr=%h wstrb=%b awaddr=%h wdata=%h want 8 0001 0 0",
                     axi.araddr, axi.wstrb, axi.awaddr, axi.wdata);
        end
        checks++; if (r_data !== '0) begin errors++; $display("FAIL reset_r_data: got %h want 0", r_data); end
        rst = 0;
        @(negedge clk);
        checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL reset_release: u_ready=%b want 1", u_ready); end
        model_rdata = '0;
    endtask

    task automatic test_tx_word(input logic [8*WB-1:0] w);
        bit got, e, wt;
        int s0, d0;
        wr_log.delete(); wr_stat_at.delete(); stat_q.delete(); stat_def = 8'h00;
        s0 = n_stat; d0 = n_txd;
        issue(1, 0, w);
        wait_done(got, e, wt);
        repeat (2) @(negedge clk);
        checks++; if (!(got && wt)) begin errors++; $display("FAIL tx_done: got=%b is_tx=%b want 1 1", got, wt); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL tx_err: got %b want 0", e); end
        checks++;
        if (wr_log.size() != WB) begin errors++; $display("FAIL tx_count: got %0d writes want %0d", wr_log.size(), WB); end
        else for (int i = 0; i < WB; i++)
            if (wr_log[i] !== 8'(w >> (8 * i))) begin
                errors++; $display("FAIL tx_byte%0d: got %h want %h", i, wr_log[i], 8'(w >> (8 * i)));
            end
        checks++; if (n_stat - s0 != WB) begin errors++; $display("FAIL tx_polls: got %0d want %0d", n_stat - s0, WB); end
        checks++; if (n_txd - d0 != 1) begin errors++; $display("FAIL tx_pulses: got %0d want 1", n_txd - d0); end
        checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL tx_idle: u_ready=%b want 1", u_ready); end
    endtask

    task automatic test_rx_word;
        bit got, e, wt;
        int d0, q0;
        stat_q.delete(); stat_def = 8'h01;
        rx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        d0 = n_rxd; q0 = n_rxrd;
        issue(0, 1, $urandom);
        wait_done(got, e, wt);
        repeat (2) @(negedge clk);
        model_rdata = 32'h44332211;
        checks++; if (!(got && !wt)) begin errors++; $display("FAIL rx_done: got=%b is_tx=%b want 1 0", got, wt); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rx_err: got %b want 0", e); end
        checks++; if (r_data !== model_rdata) begin errors++; $display("FAIL rx_data: got %h want %h", r_data, model_rdata); end
        checks++; if (n_rxd - d0 != 1 || n_rxrd - q0 != WB) begin
            errors++; $display("FAIL rx_counts: pulses=%0d reads=%0d want 1 %0d", n_rxd - d0, n_rxrd - q0, WB);
        end
    endtask

    task automatic test_tx_busy;
        bit got, e, wt;
        int s0, first;
        wr_log.delete(); wr_stat_at.delete(); stat_def = 8'h00;
        stat_q = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08};
        s0 = n_stat;
        issue(1, 0, $urandom);
        wait_done(got, e, wt);
        repeat (2) @(negedge clk);
        first = wr_stat_at.size() > 0 ? wr_stat_at[0] - s0 : -1;
        checks++; if (!(got && wt)) begin errors++; $display("FAIL busy_done: got=%b is_tx=%b want 1 1", got, wt); end
`ifdef UART_POLL_TIMEOUT_EN
        checks++; if (e !== 1'b1 || wr_log.size() != 0) begin
            errors++; $display("FAIL busy_timeout: err=%b writes=%0d want 1 0", e, wr_log.size());
        end
        checks++; if (n_stat - s0 != PL) begin errors++; $display("FAIL busy_polls: got %0d want %0d", n_stat - s0, PL); end
`else
        checks++; if (first != 6) begin errors++; $display("FAIL busy_first_write: after %0d status reads want 6", first); end
        checks++; if (n_stat - s0 != 6 + WB - 1 || e !== 1'b0) begin
            errors++; $display("FAIL busy_polls: reads=%0d err=%b want %0d 0", n_stat - s0, e, 6 + WB - 1);
        end
`endif
    endtask

    task automatic test_resp_err;
        bit got, e, wt;
        logic [8*WB-1:0] w;
        wr_log.delete(); stat_q.delete(); stat_def = 8'h00;
        aw_dly = 0; w_dly = 2; bresp_q = '{2'b10};
        w = $urandom;
        issue(1, 0, w);
        wait_done(got, e, wt);
        checks++; if (!(got && wt && e)) begin errors++; $display("FAIL bresp_err: done=%b tx=%b err=%b want 1 1 1", got, wt, e); end
        checks++; if (wr_log.size() != WB || wr_log[0] !== w[7:0]) begin
            errors++; $display("FAIL skew_write: writes=%0d want %0d", wr_log.size(), WB);
        end
        aw_dly = 3; w_dly = 0;
        issue(1, 0, $urandom);
        wait_done(got, e, wt);
        checks++; if (!(got && wt && !e)) begin errors++; $display("FAIL err_cleared: done=%b tx=%b err=%b want 1 1 0", got, wt, e); end
        aw_dly = 0; stat_def = 8'h01; rresp_q = '{2'b00, 2'b00, 2'b01};
        rx_q = '{8'hde, 8'had, 8'hbe, 8'hef};
        issue(0, 1, $urandom);
        wait_done(got, e, wt);
        model_rdata = 32'hefbeadde;
        checks++; if (!(got && !wt && e)) begin errors++; $display("FAIL rresp_err: done=%b tx=%b err=%b want 1 0 1", got, wt, e); end
        checks++; if (r_data !== model_rdata) begin errors++; $display("FAIL rresp_data: got %h want %h", r_data, model_rdata); end
    endtask

    task automatic test_priority;
        bit got, e, wt;
        int q0;
        wr_log.delete(); stat_q.delete(); stat_def = 8'h01;
        q0 = n_rxrd;
        issue(1, 1, $urandom);
        wait_done(got, e, wt);
        checks++; if (!(got && wt) || n_rxrd != q0 || wr_log.size() != WB) begin
            errors++; $display("FAIL priority: done=%b tx=%b rx_reads=%0d writes=%0d want 1 1 0 %0d",
                               got, wt, n_rxrd - q0, wr_log.size(), WB);
        end
    endtask

    task automatic test_reset_write;
        int d0, c;
        stat_q.delete(); stat_def = 8'h00; aw_dly = 40; w_dly = 40;
        d0 = n_txd + n_rxd;
        issue(1, 0, $urandom);
        for (c = 0; c < 200 && !axi.awvalid; c++) @(negedge clk);
        checks++; if (!axi.awvalid) begin errors++; $display("FAIL rst_write_reach: awvalid=%b want 1", axi.awvalid); end
        rst = 1;
        @(posedge clk); #1;
        checks++; if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, u_ready} !== 6'b0) begin
            errors++; $display("FAIL rst_write_drop: aw=%b w=%b ar=%b b=%b r=%b rdy=%b want all 0",
                               axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, u_ready);
        end
        @(negedge clk); rst = 0; aw_dly = 0; w_dly = 0;
        @(negedge clk);
        checks++; if (u_ready !== 1'b1) begin errors++; $display("FAIL rst_write_ready: got %b want 1", u_ready); end
        repeat (5) @(negedge clk);
        checks++; if (n_txd + n_rxd != d0 || r_data !== '0) begin
            errors++; $display("FAIL rst_write_nodone: pulses=%0d r_data=%h want 0 0", n_txd + n_rxd - d0, r_data);
        end
        model_rdata = '0;
    endtask

    task automatic test_timeout;
        bit got, e, wt;
        int s0, q0;
        stat_q.delete(); stat_def = 8'h00; wr_log.delete();
        s0 = n_stat; q0 = n_rxrd;
        issue(0, 1, $urandom);
        wait_done(got, e, wt);
        checks++; if (!(got && !wt && e)) begin errors++; $display("FAIL tmo_rx: done=%b tx=%b err=%b want 1 0 1", got, wt, e); end
        checks++; if (n_stat - s0 != PL || n_rxrd != q0 || r_data !== model_rdata) begin
            errors++; $display("FAIL tmo_rx_reads: status=%0d data=%0d r_data=%h want %0d 0 %h",
                               n_stat - s0, n_rxrd - q0, r_data, PL, model_rdata);
        end
        stat_def = 8'h08;
        issue(1, 0, $urandom);
        wait_done(got, e, wt);
        checks++; if (!(got && wt && e) || wr_log.size() != 0) begin
            errors++; $display("FAIL tmo_tx: done=%b tx=%b err=%b writes=%0d want 1 1 1 0", got, wt, e, wr_log.size());
        end
    endtask

    task automatic test_random(input int n);
        bit got, e, wt, tx, exp_err;
        int s0, exp_stat, busy;
        logic [8*WB-1:0] w, exp_rx;
        logic [7:0] b;
        for (int it = 0; it < n; it++) begin
            tx = 1'($urandom); w = $urandom; exp_err = 0; exp_stat = 0; exp_rx = '0;
            aw_dly = $urandom % 3; w_dly = $urandom % 3;
            stat_q.delete(); rx_q.delete(); bresp_q.delete(); rresp_q.delete(); wr_log.delete();
            stat_def = tx ? 8'h00 : 8'h01;
            for (int i = 0; i < WB; i++) begin
                busy = $urandom % 3;
                exp_stat += busy + 1;
                for (int k = 0; k < busy; k++) stat_q.push_back(tx ? (8'($urandom) | 8'h08) : (8'($urandom) & 8'hfe));
                stat_q.push_back(tx ? (8'($urandom) & 8'hf7) : (8'($urandom) | 8'h01));
                b = $urandom;
                rx_q.push_back(b);
                exp_rx = exp_rx | ((8*WB)'(b) << (8 * i));
                if ($urandom % 4 == 0) begin
                    exp_err = 1;
                    if (tx) bresp_q.push_back(2'($urandom % 3 + 1)); else rresp_q.push_back(2'($urandom % 3 + 1));
                end else begin
                    if (tx) bresp_q.push_back(2'b00); else rresp_q.push_back(2'b00);
                end
            end
            s0 = n_stat;
            issue(tx, !tx, w);
            wait_done(got, e, wt);
            if (!tx) model_rdata = exp_rx;
            checks++; if (!(got && wt == tx && e == exp_err)) begin
                errors++; $display("FAIL rand%0d_done: done=%b tx=%b err=%b want 1 %b %b", it, got, wt, e, tx, exp_err);
            end
            checks++; if (n_stat - s0 != exp_stat) begin
                errors++; $display("FAIL rand%0d_polls: got %0d want %0d", it, n_stat - s0, exp_stat);
            end
            checks++; if (r_data !== model_rdata) begin
                errors++; $display("FAIL rand%0d_rdata: got %h want %h", it, r_data, model_rdata);
            end
            if (tx) begin
                checks++;
                if (wr_log.size() != WB) begin errors++; $display("FAIL rand%0d_writes: got %0d want %0d", it, wr_log.size(), WB); end
                else for (int i = 0; i < WB; i++)
                    if (wr_log[i] !== 8'(w >> (8 * i))) begin
                        errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, wr_log[i], 8'(w >> (8 * i)));
                    end
            end
        end
        aw_dly = 0; w_dly = 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL protocol: %0d bus violations want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_tx_word(32'h0000_a55a);
        test_tx_word($urandom);
        test_rx_word;
        test_tx_busy;
        test_resp_err;
        test_priority;
        test_reset_write;
`ifdef UART_POLL_TIMEOUT_EN
        test_timeout;
`endif
        test_random(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
